trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_pkg.sv | 22 ++
 rtl/trigger_capture_ram.sv | 23 ++
 rtl/trigger_capture.sv | 177 +++++++++++++++++
 tb/tb_trigger_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared encodings for the trigger capture block: FSM states, sample event bits,
// and configuration register addresses.
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    READ  = 2'd3
  } state_t;

  localparam int EV_TRG = 0;
  localparam int EV_ABT = 1;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_PRE  = 2'd1;
  localparam logic [1:0] REG_POST = 2'd2;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/trigger_capture_ram.sv
// Simple dual-port capture RAM: one write port, one read port with 1-cycle registered read.
// Contents are deliberately not reset.
module trigger_capture_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger sample capture with streamed readout; RAM read + output register = 2 cycles,
// skid slot keeps full rate under sto_tready backpressure. TRIGGER_CAPTURE_ABORT_EN enables sti_tevent[1] abort.
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int BAW = 6,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int MAW = 10
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SEW-1:0] sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [SDW-1:0] sto_tdata,
  output logic           sto_tlast,
  output logic [1:0]     sts_state,
  output logic           sts_done
);

  localparam int PW = MAW - 1;

  state_t         state, state_nxt;
  logic [PW-1:0]  cfg_pre, cfg_post, post_cnt;
  logic [MAW-1:0] wp, fill, tadr, rp, rd_left, rd_base;
  logic           arm_stb, abt_stb, trg, abt, hit, wr_en, rd_en, enter_read;
  logic           rvld, rlast, skid_vld, skid_last, last_xfer;
  logic [SDW-1:0] rdata, skid_dat;
  logic           unused_in;

  assign bus_wready = 1'b1;
  assign sti_tready = 1'b1;
  assign sts_state  = state;
  assign unused_in  = ^{bus_waddr, bus_wdata, sti_tevent};

  assign arm_stb = bus_wvalid && (bus_waddr[1:0] == REG_CTRL) && bus_wdata[CTRL_ARM];
  assign abt_stb = bus_wvalid && (bus_waddr[1:0] == REG_CTRL) && bus_wdata[CTRL_ABORT];
  assign trg     = sti_tvalid && sti_tevent[EV_TRG];
`ifdef TRIGGER_CAPTURE_ABORT_EN
  assign abt     = abt_stb || (sti_tvalid && sti_tevent[EV_ABT]);
`else
  assign abt     = abt_stb;
`endif

  // fill counts samples stored before the current one
  assign hit        = trg && (fill >= {1'b0, cfg_pre});
  assign wr_en      = sti_tvalid && ((state == ARMED) || (state == POST));
  assign last_xfer  = sto_tvalid && sto_tready && sto_tlast;
  assign enter_read = (state != READ) && (state_nxt == READ);
  assign rd_base    = (state == ARMED) ? wp : tadr;

  // Issue a read only when the output register + skid slot can absorb the returning word
  assign rd_en = (state == READ) && (rd_left != '0) && !skid_vld &&
                 !(rvld && sto_tvalid && !sto_tready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm_stb) state_nxt = ARMED;
      ARMED: begin
        if (abt)      state_nxt = IDLE;
        else if (hit) state_nxt = (cfg_post == '0) ? READ : POST;
      end
      POST: begin
        if (abt)                                   state_nxt = IDLE;
        else if (sti_tvalid && post_cnt == PW'(1)) state_nxt = READ;
      end
      READ:    if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_pre   <= '0;
      cfg_post  <= '0;
      post_cnt  <= '0;
      wp        <= '0;
      fill      <= '0;
      tadr      <= '0;
      rp        <= '0;
      rd_left   <= '0;
      rvld      <= 1'b0;
      rlast     <= 1'b0;
      sts_done  <= 1'b0;
    end else begin
      if (bus_wvalid && bus_waddr[1:0] == REG_PRE)  cfg_pre  <= bus_wdata[PW-1:0];
      if (bus_wvalid && bus_waddr[1:0] == REG_POST) cfg_post <= bus_wdata[PW-1:0];

      if (state == IDLE && arm_stb) begin
        wp       <= '0;
        fill     <= '0;
        sts_done <= 1'b0;
      end else if (wr_en) begin
        wp <= wp + MAW'(1);
        if (state == ARMED && fill != '1) fill <= fill + MAW'(1);
      end

      if (state == ARMED && hit) begin
        tadr     <= wp;
        post_cnt <= cfg_post;
      end else if (state == POST && sti_tvalid) begin
        post_cnt <= post_cnt - PW'(1);
      end

      if (enter_read) begin
        rp      <= rd_base - {1'b0, cfg_pre};
        rd_left <= {1'b0, cfg_pre} + {1'b0, cfg_post} + MAW'(1);
      end else if (rd_en) begin
        rp      <= rp + MAW'(1);
        rd_left <= rd_left - MAW'(1);
      end

      rvld  <= rd_en;
      rlast <= rd_en && (rd_left == MAW'(1));

      if (last_xfer) sts_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
      sto_tdata  <= '0;
      skid_vld   <= 1'b0;
      skid_last  <= 1'b0;
      skid_dat   <= '0;
    end else if (!sto_tvalid || sto_tready) begin
      if (skid_vld) begin
        sto_tvalid <= 1'b1;
        sto_tlast  <= skid_last;
        sto_tdata  <= skid_dat;
        skid_vld   <= 1'b0;
      end else if (rvld) begin
        sto_tvalid <= 1'b1;
        sto_tlast  <= rlast;
        sto_tdata  <= rdata;
      end else begin
        sto_tvalid <= 1'b0;
        sto_tlast  <= 1'b0;
      end
    end else if (rvld) begin
      skid_vld  <= 1'b1;
      skid_last <= rlast;
      skid_dat  <= rdata;
    end
  end

  trigger_capture_ram #(
    .DW(SDW),
    .AW(MAW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wp),
    .wdata (sti_tdata),
    .re    (rd_en),
    .raddr (rp),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture at MAW=4: table of capture scenarios plus hand-written abort/arm/reset sequences.
module tb_trigger_capture;

  localparam int BAW = 6;
  localparam int BDW = 32;
  localparam int SDW = 32;
  localparam int SEW = 2;
  localparam int MAW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           bus_wready, bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic           sti_tready, sti_tvalid;
  logic [SEW-1:0] sti_tevent;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready, sto_tvalid, sto_tlast;
  logic [SDW-1:0] sto_tdata;
  logic [1:0]     sts_state;
  logic           sts_done;

  always #5 clk = ~clk;

  trigger_capture #(
    .BAW(BAW), .BDW(BDW), .SDW(SDW), .SEW(SEW), .MAW(MAW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_wready (bus_wready),
    .bus_wvalid (bus_wvalid),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .sti_tready (sti_tready),
    .sti_tvalid (sti_tvalid),
    .sti_tevent (sti_tevent),
    .sti_tdata  (sti_tdata),
    .sto_tready (sto_tready),
    .sto_tvalid (sto_tvalid),
    .sto_tdata  (sto_tdata),
    .sto_tlast  (sto_tlast),
    .sts_state  (sts_state),
    .sts_done   (sts_done)
  );

  typedef struct {
    int pre;
    int post;
    int trig;
    int ign;
    int first;
    int n;
    bit stall;
  } vec_t;

  vec_t           vecs [7];
  logic [SDW:0]   exp_q [$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             n_pop   = 0;
  int             cyc     = 0;
  bit             stall_mode = 1'b0;
  bit             prev_stall = 1'b0;
  logic [SDW-1:0] prev_dat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs at the negedge: a word seen valid&ready here is the one transferred at the next posedge
  task automatic monitor();
    logic [SDW:0] e;
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("hold_vld", sto_tvalid, 1);
      check("hold_dat", sto_tdata, prev_dat);
    end
    if (sto_tvalid && sto_tready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_word: got %0h, expected no word", sto_tdata);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", sto_tdata, e[SDW-1:0]);
        check("rd_last", sto_tlast, e[SDW]);
        n_pop++;
      end
    end
    prev_stall = sto_tvalid && !sto_tready;
    prev_dat   = sto_tdata;
  endtask

  task automatic step();
    sto_tready = !(stall_mode && (cyc % 3 == 1));
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input int addr, input int data);
    bus_wvalid = 1'b1;
    bus_waddr  = BAW'(addr);
    bus_wdata  = BDW'(data);
    step();
    bus_wvalid = 1'b0;
  endtask

  task automatic expect_words(input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), SDW'(first + k)});
  endtask

  task automatic feed(input int base, input int n, input int trig, input int ign, input int abt_i);
    for (int i = 0; i < n; i++) begin
      sti_tvalid    = 1'b1;
      sti_tdata     = SDW'(base + i);
      sti_tevent    = '0;
      sti_tevent[0] = (trig >= 0 && i >= trig) || (i == ign);
      sti_tevent[1] = (i == abt_i);
      step();
    end
    sti_tvalid = 1'b0;
    sti_tevent = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((sts_state != 2'd0 || exp_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    check(name, (k < budget), 1);
    check("q_empty", exp_q.size(), 0);
  endtask

  task automatic run_capture(input vec_t v, input int base);
    stall_mode = v.stall;
    wr(1, v.pre);
    wr(2, v.post);
    wr(0, 1);
    check("armed", sts_state, 1);
    check("done_clr", sts_done, 0);
    expect_words(base + v.first, v.n);
    feed(base, v.trig + v.post + 3, v.trig, v.ign, -1);
    wait_idle("cap_timeout", 300);
    check("done_set", sts_done, 1);
    check("end_state", sts_state, 0);
    stall_mode = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0, k;

    //          pre post trig ign first  n  stall
    vecs[0] = '{3,  2,   5,  -1,  2,   6,  1'b0};
    vecs[1] = '{3,  2,   4,   1,  1,   6,  1'b0};
    vecs[2] = '{7,  7,  40,  -1, 33,  15,  1'b0};
    vecs[3] = '{7,  7,  38,  -1, 31,  15,  1'b0};
    vecs[4] = '{0,  0,   0,  -1,  0,   1,  1'b0};
    vecs[5] = '{5,  0,   9,  -1,  4,   6,  1'b0};
    vecs[6] = '{7,  7,  20,  -1, 13,  15,  1'b1};

    rst        = 1'b1;
    bus_wvalid = 1'b0;
    bus_waddr  = '0;
    bus_wdata  = '0;
    sti_tvalid = 1'b0;
    sti_tevent = '0;
    sti_tdata  = '0;
    sto_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdata", sto_tdata, 0);
    check("rst_tvalid", sto_tvalid, 0);
    rst = 1'b0;
    step();
    check("rst_state", sts_state, 0);
    check("rst_done", sts_done, 0);
    check("rst_tlast", sto_tlast, 0);
    check("wready", bus_wready, 1);
    check("sti_tready", sti_tready, 1);

    for (int t = 0; t < 7; t++) run_capture(vecs[t], (t + 1) << 8);

    // Trigger and abort on the same sample
    wr(1, 0);
    wr(2, 2);
    wr(0, 1);
`ifndef TRIGGER_CAPTURE_ABORT_EN
    expect_words(16'h0902, 3);
`endif
    feed(16'h0900, 5, 2, -1, 2);
    wait_idle("ta_timeout", 100);
    repeat (4) step();
    check("ta_state", sts_state, 0);
    check("ta_tvalid", sto_tvalid, 0);
`ifdef TRIGGER_CAPTURE_ABORT_EN
    check("ta_done", sts_done, 0);
`else
    check("ta_done", sts_done, 1);
`endif

    // Bus abort while collecting post-trigger samples
    wr(1, 0);
    wr(2, 5);
    wr(0, 1);
    feed(16'h0A00, 2, 1, -1, -1);
    check("post_state", sts_state, 2);
    wr(0, 2);
    check("bab_state", sts_state, 0);
    repeat (4) step();
    check("bab_done", sts_done, 0);
    check("bab_tvalid", sto_tvalid, 0);

    // A second arm while ARMED must not restart the fill count
    wr(1, 2);
    wr(2, 1);
    wr(0, 1);
    feed(16'h0B00, 3, -1, -1, -1);
    wr(0, 1);
    check("rearm_state", sts_state, 1);
    expect_words(16'h0B01, 4);
    for (int i = 3; i < 5; i++) begin
      sti_tvalid    = 1'b1;
      sti_tdata     = SDW'(16'h0B00 + i);
      sti_tevent    = '0;
      sti_tevent[0] = (i == 3);
      step();
    end
    sti_tvalid = 1'b0;
    sti_tevent = '0;
    wait_idle("rearm_timeout", 100);
    check("rearm_done", sts_done, 1);

    // Reset in the middle of a readout, then a fresh capture
    wr(1, 7);
    wr(2, 7);
    wr(0, 1);
    expect_words(16'h0C0D, 15);
    feed(16'h0C00, 28, 20, -1, -1);
    pop0 = n_pop;
    k = 0;
    while (n_pop < pop0 + 3 && k < 100) begin
      step();
      k++;
    end
    check("mid_read_state", sts_state, 3);
    rst = 1'b1;
    #1;
    check("mr_tvalid", sto_tvalid, 0);
    check("mr_state", sts_state, 0);
    check("mr_tdata", sto_tdata, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("mr_done", sts_done, 0);
    run_capture(vecs[0], 16'h0D00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
